// File: rtl/miner_csr.sv
// Avalon-MM control/status register block for a SHA-based miner core.
// Optional MINER_CSR_ATOMIC64_EN adds a shadow register so the 64-bit solution reads as one snapshot.
module miner_csr (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   avs_address,
  input  logic         avs_read,
  input  logic         avs_write,
  input  logic [31:0]  avs_writedata,
  output logic [31:0]  avs_readdata,
  output logic         avs_readdatavalid,
  output logic [255:0] header,
  output logic [255:0] difficulty,
  output logic [63:0]  start_nonce,
  output logic [18:0]  control,
  input  logic [63:0]  solution,
  input  logic [6:0]   status,
  input  logic         miner_irq,
  input  logic         bsy,
  output logic         irq
);

  localparam logic [4:0]  ADDR_NONCE_LO = 5'h10;
  localparam logic [4:0]  ADDR_NONCE_HI = 5'h11;
  localparam logic [4:0]  ADDR_CONTROL  = 5'h12;
  localparam logic [4:0]  ADDR_STATUS   = 5'h13;
  localparam logic [4:0]  ADDR_SOL_LO   = 5'h14;
  localparam logic [4:0]  ADDR_SOL_HI   = 5'h15;
  localparam logic [4:0]  ADDR_IRQ_PEND = 5'h16;
  localparam logic [4:0]  ADDR_IRQ_EN   = 5'h17;
  localparam logic [4:0]  ADDR_ID       = 5'h18;
  localparam logic [4:0]  ADDR_BUSY     = 5'h19;
  localparam logic [31:0] ID_VALUE      = 32'h5348_4133;

  logic [7:0][31:0] header_r;
  logic [7:0][31:0] difficulty_r;
  logic [1:0][31:0] nonce_r;
  logic             irq_pending;
  logic             irq_enable;
  logic             miner_irq_q;
  logic [31:0]      busy_cycles;
  logic [31:0]      rd_data;
  logic             rd_accept;
  logic             irq_rise;
  logic             irq_clear;
  logic             run_start;

  assign header      = header_r;
  assign difficulty  = difficulty_r;
  assign start_nonce = nonce_r;

  // A simultaneous write wins; the read is dropped entirely.
  assign rd_accept = avs_read && !avs_write;
  assign irq_rise  = miner_irq && !miner_irq_q;
  assign irq_clear = avs_write && (avs_address == ADDR_IRQ_PEND) && avs_writedata[0];
  assign run_start = avs_write && (avs_address == ADDR_CONTROL) &&
                     avs_writedata[0] && !control[0];

`ifdef MINER_CSR_ATOMIC64_EN
  logic [31:0] sol_shadow;

  always_ff @(posedge clk) begin
    if (rst)
      sol_shadow <= '0;
    else if (rd_accept && (avs_address == ADDR_SOL_LO))
      sol_shadow <= solution[63:32];
  end
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    rd_data = '0;
    if (avs_address[4:3] == 2'b00) begin
      rd_data = header_r[avs_address[2:0]];
    end else if (avs_address[4:3] == 2'b01) begin
      rd_data = difficulty_r[avs_address[2:0]];
    end else begin
      case (avs_address)
        ADDR_NONCE_LO: rd_data = nonce_r[0];
        ADDR_NONCE_HI: rd_data = nonce_r[1];
        ADDR_CONTROL:  rd_data = {13'd0, control};
        ADDR_STATUS:   rd_data = {25'd0, status};
        ADDR_SOL_LO:   rd_data = solution[31:0];
`ifdef MINER_CSR_ATOMIC64_EN
        ADDR_SOL_HI:   rd_data = sol_shadow;
`else
        ADDR_SOL_HI:   rd_data = solution[63:32];
`endif
        ADDR_IRQ_PEND: rd_data = {31'd0, irq_pending};
        ADDR_IRQ_EN:   rd_data = {31'd0, irq_enable};
        ADDR_ID:       rd_data = ID_VALUE;
        ADDR_BUSY:     rd_data = busy_cycles;
        default:       rd_data = '0;
      endcase
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      header_r          <= '0;
      difficulty_r      <= '0;
      nonce_r           <= '0;
      control           <= '0;
      irq_pending       <= 1'b0;
      irq_enable        <= 1'b0;
      miner_irq_q       <= 1'b0;
      busy_cycles       <= '0;
      irq               <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      miner_irq_q <= miner_irq;

      if (avs_write) begin
        if (avs_address[4:3] == 2'b00) begin
          header_r[avs_address[2:0]] <= avs_writedata;
        end else if (avs_address[4:3] == 2'b01) begin
          difficulty_r[avs_address[2:0]] <= avs_writedata;
        end else begin
          case (avs_address)
            ADDR_NONCE_LO: nonce_r[0] <= avs_writedata;
            ADDR_NONCE_HI: nonce_r[1] <= avs_writedata;
            ADDR_CONTROL:  control    <= avs_writedata[18:0];
            ADDR_IRQ_EN:   irq_enable <= avs_writedata[0];
            default: ;
          endcase
        end
      end

      // A new miner edge outranks a concurrent write-1-to-clear.
      if (irq_rise)
        irq_pending <= 1'b1;
      else if (irq_clear)
        irq_pending <= 1'b0;

      if (run_start)
        busy_cycles <= '0;
      else if (bsy && (busy_cycles != 32'hFFFF_FFFF))
        busy_cycles <= busy_cycles + 32'd1;

      irq <= irq_pending && irq_enable;

      if (rd_accept) begin
        avs_readdatavalid <= 1'b1;
        avs_readdata      <= rd_data;
      end else begin
        avs_readdatavalid <= 1'b0;
        avs_readdata      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_miner_csr.sv
// Self-checking bench for miner_csr: a register access table plus directed irq, busy-counter,
// solution-snapshot and reset sequences.
module tb_miner_csr;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   avs_address;
  logic         avs_read;
  logic         avs_write;
  logic [31:0]  avs_writedata;
  logic [31:0]  avs_readdata;
  logic         avs_readdatavalid;
  logic [255:0] header;
  logic [255:0] difficulty;
  logic [63:0]  start_nonce;
  logic [18:0]  control;
  logic [63:0]  solution;
  logic [6:0]   status;
  logic         miner_irq;
  logic         bsy;
  logic         irq;

  int checks = 0;
  int errors = 0;

  miner_csr dut (
    .clk(clk), .rst(rst),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .header(header), .difficulty(difficulty), .start_nonce(start_nonce),
    .control(control), .solution(solution), .status(status),
    .miner_irq(miner_irq), .bsy(bsy), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp);
    avs_address = addr;
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
    check($sformatf("rd valid 0x%0h", addr), 256'(avs_readdatavalid), 256'(1));
    check($sformatf("rd data 0x%0h", addr), 256'(avs_readdata), 256'(exp));
    tick();
    check($sformatf("rd idle valid 0x%0h", addr), 256'(avs_readdatavalid), 256'(0));
    check($sformatf("rd idle data 0x%0h", addr), 256'(avs_readdata), 256'(0));
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    solution = 64'hCAFEBABE_12345678; status = 7'h5A; miner_irq = 1'b0; bsy = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("reset header", header, 256'd0);
    check("reset difficulty", difficulty, 256'd0);
    check("reset nonce", 256'(start_nonce), 256'd0);
    check("reset control", 256'(control), 256'd0);
    check("reset irq", 256'(irq), 256'd0);
    check("reset valid", 256'(avs_readdatavalid), 256'd0);
    check("reset readdata", 256'(avs_readdata), 256'd0);

    // Header word write lands on the port one edge later, other words untouched.
    wr(5'h03, 32'h01234567);
    check("header word3", header, 256'h01234567 << 96);

    vecs.push_back('{1'b0, 5'h03, 32'h01234567});
    vecs.push_back('{1'b0, 5'h18, 32'h53484133});
    vecs.push_back('{1'b0, 5'h1F, 32'h00000000});
    vecs.push_back('{1'b0, 5'h1A, 32'h00000000});
    vecs.push_back('{1'b1, 5'h08, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 5'h08, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 5'h10, 32'h11111111});
    vecs.push_back('{1'b1, 5'h11, 32'h22222222});
    vecs.push_back('{1'b0, 5'h10, 32'h11111111});
    vecs.push_back('{1'b0, 5'h11, 32'h22222222});
    vecs.push_back('{1'b1, 5'h13, 32'hFFFFFFFF});
    vecs.push_back('{1'b0, 5'h13, 32'h0000005A});
    vecs.push_back('{1'b1, 5'h18, 32'h00000000});
    vecs.push_back('{1'b0, 5'h18, 32'h53484133});
    vecs.push_back('{1'b1, 5'h12, 32'hFFFFFFFF});
    vecs.push_back('{1'b0, 5'h12, 32'h0007FFFF});
    vecs.push_back('{1'b1, 5'h12, 32'h00000000});
    vecs.push_back('{1'b0, 5'h14, 32'h12345678});
    vecs.push_back('{1'b0, 5'h15, 32'hCAFEBABE});
    vecs.push_back('{1'b1, 5'h17, 32'hFFFFFFFF});
    vecs.push_back('{1'b0, 5'h17, 32'h00000001});
    vecs.push_back('{1'b1, 5'h17, 32'h00000000});
    vecs.push_back('{1'b0, 5'h17, 32'h00000000});
    vecs.push_back('{1'b1, 5'h1F, 32'hFFFFFFFF});
    vecs.push_back('{1'b0, 5'h1F, 32'h00000000});
    vecs.push_back('{1'b0, 5'h07, 32'h00000000});

    foreach (vecs[i]) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
      else            rd(vecs[i].addr, vecs[i].data);
    end

    check("difficulty port", difficulty, 256'hDEADBEEF);
    check("nonce port", 256'(start_nonce), 256'h22222222_11111111);
    check("header port kept", header, 256'h01234567 << 96);

    // Back-to-back reads return data on consecutive cycles.
    avs_read = 1'b1; avs_address = 5'h18;
    tick();
    avs_address = 5'h13;
    check("b2b valid0", 256'(avs_readdatavalid), 256'd1);
    check("b2b data0", 256'(avs_readdata), 256'h53484133);
    tick();
    avs_read = 1'b0;
    check("b2b valid1", 256'(avs_readdatavalid), 256'd1);
    check("b2b data1", 256'(avs_readdata), 256'h5A);
    tick();
    check("b2b idle", 256'(avs_readdatavalid), 256'd0);

    // Read and write together: write performed, read dropped.
    wr(5'h17, 32'h1);
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 5'h17; avs_writedata = 32'h0;
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
    check("rw collide valid", 256'(avs_readdatavalid), 256'd0);
    rd(5'h17, 32'h0);

    // Interrupt: irq two edges after the miner edge, set beats W1C.
    wr(5'h17, 32'h1);
    miner_irq = 1'b1;
    tick();
    check("irq after 1 edge", 256'(irq), 256'd0);
    tick();
    check("irq after 2 edges", 256'(irq), 256'd1);
    miner_irq = 1'b0;
    tick();
    miner_irq = 1'b1;
    wr(5'h16, 32'h1);
    rd(5'h16, 32'h1);
    check("irq held", 256'(irq), 256'd1);
    wr(5'h16, 32'h0);
    rd(5'h16, 32'h1);
    wr(5'h16, 32'h1);
    rd(5'h16, 32'h0);
    check("irq cleared", 256'(irq), 256'd0);

    // Busy counter: run start clears, re-write does not, clear beats increment.
    wr(5'h12, 32'h1);
    bsy = 1'b1;
    repeat (10) tick();
    bsy = 1'b0;
    rd(5'h19, 32'd10);
    wr(5'h12, 32'h1);
    rd(5'h19, 32'd10);
    wr(5'h12, 32'h0);
    bsy = 1'b1;
    wr(5'h12, 32'h1);
    bsy = 1'b0;
    rd(5'h19, 32'd0);
    bsy = 1'b1;
    repeat (3) tick();
    bsy = 1'b0;
    rd(5'h19, 32'd3);

    // Solution snapshot.
    solution = 64'h00000001_FFFFFFFF;
    rd(5'h14, 32'hFFFFFFFF);
    solution = 64'h00000002_00000000;
`ifdef MINER_CSR_ATOMIC64_EN
    rd(5'h15, 32'h00000001);
`else
    rd(5'h15, 32'h00000002);
`endif

    // Reset mid-run with a read issued on the reset cycle.
    wr(5'h12, 32'h7FFFF);
    miner_irq = 1'b0;
    tick();
    miner_irq = 1'b1;
    tick(); tick();
    check("irq before reset", 256'(irq), 256'd1);
    check("control before reset", 256'(control), 256'h7FFFF);
    avs_read = 1'b1; avs_address = 5'h18; rst = 1'b1;
    tick();
    avs_read = 1'b0; rst = 1'b0;
    check("rst valid", 256'(avs_readdatavalid), 256'd0);
    check("rst control", 256'(control), 256'd0);
    check("rst irq", 256'(irq), 256'd0);
    check("rst header", header, 256'd0);
    tick();
    check("rst valid after", 256'(avs_readdatavalid), 256'd0);
    rd(5'h17, 32'h0);
    rd(5'h19, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
